branch_redirect_ctrl: RTL and testbench
=======================================

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 The block SHALL have parameter GHSR_W, default GSHARE_GHSR_WIDTH, meaning global history width.
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 2, range 0..15, meaning issue-stall cycles after redirect acceptance.
REQ-003 The block SHALL have port clk  in  1  as its single clock, with all state on the rising edge.
REQ-004 The block SHALL have port reset_n  in  1  as the reset, asynchronous and active-low.
REQ-005 The block SHALL have port bj_valid  in  1, meaning the branch/jump unit resolved a branch or jump this cycle.
REQ-006 The block SHALL have port bj_flush  in  1, meaning a mispredict (direction or target) was detected.
REQ-007 The block SHALL have port bj_target_pc  in  32, meaning the resolved next PC.
REQ-008 The block SHALL have port bj_taken  in  1, meaning the resolved direction.
REQ-009 The block SHALL have port bj_update_ghsr  in  1, meaning the history register must be rewritten.
REQ-010 The block SHALL have port bj_ghsr_restore  in  GHSR_W, meaning the history before this branch.
REQ-011 The block SHALL have port fetch_ready  in  1, meaning fetch accepts a redirect.
REQ-012 The block SHALL have port redirect_valid  out  1 and port redirect_pc  out  32, carrying the redirect to fetch.
REQ-013 The block SHALL have port ghsr_wr_en  out  1 and port ghsr_wr_data  out  GHSR_W, carrying the history write to the predictor.
REQ-014 The block SHALL have port flush_front  out  1, meaning kill fetch/decode, and port flush_back  out  1, meaning kill issue queues and execute.
REQ-015 The block SHALL have port stall_issue  out  1 and port busy  out  1, where busy is high whenever state is not IDLE.

Function
REQ-016 The block SHALL implement FSM states IDLE, REDIRECT and DRAIN.
REQ-017 In IDLE, when bj_valid and bj_flush are both high, the block SHALL capture bj_target_pc into pc_q and {bj_ghsr_restore[GHSR_W-2:0], bj_taken} into ghsr_q, and SHALL enter REDIRECT on the next edge.
REQ-018 On the first REDIRECT cycle only, the block SHALL pulse flush_front and flush_back for 1 cycle, and SHALL pulse ghsr_wr_en for 1 cycle if bj_update_ghsr was high at capture.
REQ-019 In REDIRECT, the block SHALL hold redirect_valid=1 with redirect_pc=pc_q stable until the redirect_valid and fetch_ready handshake completes.
REQ-020 On the handshake, the block SHALL go to DRAIN if DRAIN_CYCLES>0 and to IDLE otherwise.
REQ-021 In DRAIN, the block SHALL hold stall_issue=1 for exactly DRAIN_CYCLES cycles, counted with a 4-bit down-counter, and SHALL enter IDLE when the count reaches 0.
REQ-022 In IDLE, when bj_valid=1, bj_flush=0 and bj_update_ghsr=1, the block SHALL assert ghsr_wr_en for 1 cycle on the next cycle with ghsr_wr_data={bj_ghsr_restore[GHSR_W-2:0], bj_taken}, without leaving IDLE.
REQ-023 In REDIRECT and DRAIN, the block SHALL ignore all bj_* inputs, because younger branches are squashed by flush_back.
REQ-024 If fetch_ready is already high on the first REDIRECT cycle, the redirect SHALL complete in that cycle, giving 1-cycle latency from capture edge to fetch handshake.
REQ-025 When bj_valid is low, bj_flush SHALL be ignored.
REQ-026 ghsr_wr_data SHALL hold its last written value when ghsr_wr_en=0.

Reset
REQ-027 On reset_n low, the block SHALL immediately and asynchronously force state IDLE, pc_q=0, ghsr_q=0, counter=0, and all outputs to 0.
REQ-028 A reset during REDIRECT or DRAIN SHALL abandon the redirect, and no redirect_valid SHALL appear after release.
REQ-029 After reset release, the first capture SHALL be possible on the first rising edge.

Configuration
REQ-030 The block SHALL support the macro BRU_PERF_CNT_EN; when it is defined, the block SHALL add outputs perf_branches (32) and perf_mispredicts (32), incremented on bj_valid in IDLE and on capture respectively.
REQ-031 With BRU_PERF_CNT_EN defined, both counters SHALL wrap at 2^32, reset to 0, and stop counting while busy.
REQ-032 Without BRU_PERF_CNT_EN, the counter ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL drive bj_valid=1, bj_flush=1, bj_target_pc=0x0000_1040 with fetch_ready=1 and SHALL check, on the next cycle, redirect_valid=1, redirect_pc=0x1040, flush_front=flush_back=1, then stall_issue=1 for 2 cycles, then IDLE.
REQ-034 The bench SHALL hold fetch_ready=0 for 5 cycles after a flush and SHALL check redirect_valid held for 6 cycles with redirect_pc stable, flush pulses once only, and DRAIN starting after the handshake.
REQ-035 The bench SHALL drive GHSR_W=8 with bj_ghsr_restore=0xA5, bj_taken=1 and bj_update_ghsr=1, without flush, and SHALL check ghsr_wr_en=1 and ghsr_wr_data=0x4B on the next cycle with state staying IDLE.
REQ-036 The bench SHALL inject a second bj_valid=1, bj_flush=1 with target 0x2000 during DRAIN and SHALL check it is ignored, with no new redirect.
REQ-037 The bench SHALL pull reset_n low for 1 cycle in mid-REDIRECT and SHALL check all outputs are 0 asynchronously, with no redirect after release.
REQ-038 With BRU_PERF_CNT_EN defined, the bench SHALL drive 3 resolves (1 mispredict) and SHALL check perf_branches=3 and perf_mispredicts=1.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: turns a resolved mispredict into a fetch redirect, flush pulses,
// a history write and an issue drain. Optional perf counters are enabled by BRU_PERF_CNT_EN.
`ifndef GSHARE_GHSR_WIDTH
`define GSHARE_GHSR_WIDTH 8
`endif

module branch_redirect_ctrl #(
   parameter int GHSR_W       = `GSHARE_GHSR_WIDTH,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              bj_valid,
   input  logic              bj_flush,
   input  logic [31:0]       bj_target_pc,
   input  logic              bj_taken,
   input  logic              bj_update_ghsr,
   input  logic [GHSR_W-1:0] bj_ghsr_restore,
   input  logic              fetch_ready,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
   output logic              ghsr_wr_en,
   output logic [GHSR_W-1:0] ghsr_wr_data,
   output logic              flush_front,
   output logic              flush_back,
   output logic              stall_issue,
`ifdef BRU_PERF_CNT_EN
   output logic [31:0]       perf_branches,
   output logic [31:0]       perf_mispredicts,
`endif
   output logic              busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, REDIRECT = 2'd1, DRAIN = 2'd2} state_e;

   // Counter is loaded with one less than the drain length so DRAIN lasts exactly DRAIN_CYCLES.
   localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [GHSR_W-1:0] ghsr_q, ghsr_d;
   logic [GHSR_W-1:0] wr_hold_q;
   logic [GHSR_W-1:0] hist_new;
   logic              first_q, first_d;
   logic              wr_en_q, wr_en_d;
   logic [3:0]        cnt_q, cnt_d;

   // Shift the resolved direction into the pre-branch history; the oldest bit falls off.
   assign hist_new = GHSR_W'({bj_ghsr_restore, bj_taken});

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ghsr_d  = ghsr_q;
      cnt_d   = cnt_q;
      first_d = 1'b0;
      wr_en_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bj_valid) begin
               if (bj_flush) begin
                  pc_d    = bj_target_pc;
                  ghsr_d  = hist_new;
                  first_d = 1'b1;
                  wr_en_d = bj_update_ghsr;
                  state_d = REDIRECT;
               end else if (bj_update_ghsr) begin
                  ghsr_d  = hist_new;
                  wr_en_d = 1'b1;
               end
            end
         end
         REDIRECT: begin
            if (fetch_ready) begin
               if (DRAIN_CYCLES > 0) begin
                  state_d = DRAIN;
                  cnt_d   = DRAIN_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DRAIN: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         ghsr_q    <= '0;
         wr_hold_q <= '0;
         cnt_q     <= '0;
         first_q   <= 1'b0;
         wr_en_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ghsr_q  <= ghsr_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         wr_en_q <= wr_en_d;
         if (wr_en_q) begin
            wr_hold_q <= ghsr_q;
         end
      end
   end

   // History output only moves on a write; otherwise it shows the last value written.
   assign ghsr_wr_en     = wr_en_q;
   assign ghsr_wr_data   = wr_en_q ? ghsr_q : wr_hold_q;
   assign redirect_valid = (state_q == REDIRECT);
   assign redirect_pc    = pc_q;
   assign flush_front    = first_q;
   assign flush_back     = first_q;
   assign stall_issue    = (state_q == DRAIN);
   assign busy           = (state_q != IDLE);

`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_br_q, perf_mp_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_br_q <= '0;
         perf_mp_q <= '0;
      end else if ((state_q == IDLE) && bj_valid) begin
         perf_br_q <= perf_br_q + 32'd1;
         if (bj_flush) begin
            perf_mp_q <= perf_mp_q + 32'd1;
         end
      end
   end

   assign perf_branches    = perf_br_q;
   assign perf_mispredicts = perf_mp_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: expected output cycles are queued by the stimulus
// and popped by a monitor whenever the DUT shows any activity.
`timescale 1ns/1ps

module tb_branch_redirect_ctrl;

   logic        clk;
   logic        reset_n;
   logic        bj_valid;
   logic        bj_flush;
   logic [31:0] bj_target_pc;
   logic        bj_taken;
   logic        bj_update_ghsr;
   logic [7:0]  bj_ghsr_restore;
   logic        fetch_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ghsr_wr_en;
   logic [7:0]  ghsr_wr_data;
   logic        flush_front;
   logic        flush_back;
   logic        stall_issue;
   logic        busy;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;
`endif

   branch_redirect_ctrl #(
      .GHSR_W      (8),
      .DRAIN_CYCLES(2)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .bj_valid        (bj_valid),
      .bj_flush        (bj_flush),
      .bj_target_pc    (bj_target_pc),
      .bj_taken        (bj_taken),
      .bj_update_ghsr  (bj_update_ghsr),
      .bj_ghsr_restore (bj_ghsr_restore),
      .fetch_ready     (fetch_ready),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .ghsr_wr_en      (ghsr_wr_en),
      .ghsr_wr_data    (ghsr_wr_data),
      .flush_front     (flush_front),
      .flush_back      (flush_back),
      .stall_issue     (stall_issue),
`ifdef BRU_PERF_CNT_EN
      .perf_branches   (perf_branches),
      .perf_mispredicts(perf_mispredicts),
`endif
      .busy            (busy)
   );

   typedef struct {
      logic        rv;
      logic [31:0] pc;
      logic        fl;
      logic        we;
      logic [7:0]  wd;
      logic        st;
      logic        bz;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_ev(input logic rv, input logic [31:0] pc, input logic fl,
                            input logic we, input logic [7:0] wd, input logic st, input logic bz);
      exp_t e;
      e.rv = rv; e.pc = pc; e.fl = fl; e.we = we; e.wd = wd; e.st = st; e.bz = bz;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_bj();
      bj_valid        = 1'b0;
      bj_flush        = 1'b0;
      bj_target_pc    = 32'h0;
      bj_taken        = 1'b0;
      bj_update_ghsr  = 1'b0;
      bj_ghsr_restore = 8'h00;
   endtask

   task automatic drive_bj(input logic fl, input logic [31:0] pc, input logic upd,
                           input logic [7:0] rst_hist, input logic tk);
      bj_valid        = 1'b1;
      bj_flush        = fl;
      bj_target_pc    = pc;
      bj_update_ghsr  = upd;
      bj_ghsr_restore = rst_hist;
      bj_taken        = tk;
   endtask

   initial begin : main
      fork
         forever begin : monitor
            @(negedge clk);
            if (reset_n && (redirect_valid || flush_front || flush_back || ghsr_wr_en
                            || stall_issue || busy)) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_event: rv=%0b pc=%0h fl=%0b%0b we=%0b wd=%0h st=%0b busy=%0b",
                           redirect_valid, redirect_pc, flush_front, flush_back, ghsr_wr_en,
                           ghsr_wr_data, stall_issue, busy);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  if (redirect_valid !== e.rv || (e.rv && redirect_pc !== e.pc)
                      || flush_front !== e.fl || flush_back !== e.fl || ghsr_wr_en !== e.we
                      || ghsr_wr_data !== e.wd || stall_issue !== e.st || busy !== e.bz) begin
                     bad++;
                     $display("FAIL event_%0d: got rv=%0b pc=%0h fl=%0b%0b we=%0b wd=%0h st=%0b busy=%0b want rv=%0b pc=%0h fl=%0b we=%0b wd=%0h st=%0b busy=%0b",
                              total, redirect_valid, redirect_pc, flush_front, flush_back,
                              ghsr_wr_en, ghsr_wr_data, stall_issue, busy,
                              e.rv, e.pc, e.fl, e.we, e.wd, e.st, e.bz);
                  end
               end
            end
         end
      join_none

      reset_n     = 1'b0;
      fetch_ready = 1'b0;
      clear_bj();
      repeat (3) @(posedge clk);
      #2;
      chk("reset_outputs",
          64'({redirect_valid, redirect_pc, ghsr_wr_en, ghsr_wr_data, flush_front, flush_back,
               stall_issue, busy}), 64'h0);

      // Mispredict with fetch ready, captured on the first edge after reset release.
      fetch_ready = 1'b1;
      drive_bj(1'b1, 32'h0000_1040, 1'b0, 8'h00, 1'b0);
      expect_ev(1'b1, 32'h1040, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      expect_ev(1'b0, 32'h0,    1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      expect_ev(1'b0, 32'h0,    1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      #1 reset_n = 1'b1;
      step();
      clear_bj();
      repeat (4) step();

      // Fetch back-pressure for 5 cycles; history write rides on the first redirect cycle.
      fetch_ready = 1'b0;
      drive_bj(1'b1, 32'h0000_3000, 1'b1, 8'h0F, 1'b0);
      expect_ev(1'b1, 32'h3000, 1'b1, 1'b1, 8'h1E, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) expect_ev(1'b1, 32'h3000, 1'b0, 1'b0, 8'h1E, 1'b0, 1'b1);
      expect_ev(1'b0, 32'h0, 1'b0, 1'b0, 8'h1E, 1'b1, 1'b1);
      expect_ev(1'b0, 32'h0, 1'b0, 1'b0, 8'h1E, 1'b1, 1'b1);
      step();
      clear_bj();
      repeat (5) step();
      fetch_ready = 1'b1;
      repeat (5) step();

      // Correctly predicted branch with history update: write 0x4B, stay idle.
      drive_bj(1'b0, 32'h0000_0000, 1'b1, 8'hA5, 1'b1);
      expect_ev(1'b0, 32'h0, 1'b0, 1'b1, 8'h4B, 1'b0, 1'b0);
      step();
      clear_bj();
      repeat (3) step();

      // Second mispredict injected during DRAIN must be ignored.
      drive_bj(1'b1, 32'h0000_5000, 1'b0, 8'h00, 1'b0);
      expect_ev(1'b1, 32'h5000, 1'b1, 1'b0, 8'h4B, 1'b0, 1'b1);
      expect_ev(1'b0, 32'h0,    1'b0, 1'b0, 8'h4B, 1'b1, 1'b1);
      expect_ev(1'b0, 32'h0,    1'b0, 1'b0, 8'h4B, 1'b1, 1'b1);
      step();
      clear_bj();
      step();
      drive_bj(1'b1, 32'h0000_2000, 1'b1, 8'hFF, 1'b1);
      step();
      clear_bj();
      repeat (4) step();

      // Reset in mid-REDIRECT abandons the redirect.
      fetch_ready = 1'b0;
      drive_bj(1'b1, 32'h0000_7000, 1'b1, 8'h01, 1'b1);
      expect_ev(1'b1, 32'h7000, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1);
      step();
      clear_bj();
      step();
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          64'({redirect_valid, redirect_pc, ghsr_wr_en, ghsr_wr_data, flush_front, flush_back,
               stall_issue, busy}), 64'h0);
      @(posedge clk);
      #3 reset_n = 1'b1;
      fetch_ready = 1'b1;
      repeat (5) step();

      // Three resolves (one mispredict) plus one ignored resolve during DRAIN.
      drive_bj(1'b0, 32'h0000_0000, 1'b0, 8'h00, 1'b0);
      step();
      drive_bj(1'b0, 32'h0000_0000, 1'b1, 8'h00, 1'b0);
      expect_ev(1'b0, 32'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step();
      drive_bj(1'b1, 32'h0000_9000, 1'b0, 8'h00, 1'b0);
      expect_ev(1'b1, 32'h9000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      expect_ev(1'b0, 32'h0,    1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      expect_ev(1'b0, 32'h0,    1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      step();
      clear_bj();
      step();
      drive_bj(1'b0, 32'h0000_0000, 1'b1, 8'hFF, 1'b1);
      step();
      clear_bj();
      repeat (4) step();

`ifdef BRU_PERF_CNT_EN
      chk("perf_branches", 64'(perf_branches), 64'd3);
      chk("perf_mispredicts", 64'(perf_mispredicts), 64'd1);
`endif
      chk("events_left", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
